reg_scoreboard: RTL and testbench
=================================

// Module: reg_scoreboard
// PURPOSE
//  Tracks pending writes to the 31 architectural registers ($1..$31) of the register file.
//  Sits beside the ID stage: issues are checked against pending destinations, and a stall is raised on RAW/WAW hazards.
//  Pending bits are cleared when the write lands at the register-file W port.
//  Lets multi-cycle units (MDU, load miss) write back out of order without corrupting operands.
// PARAMETERS
//  NREG          32  architectural registers; entry 0 is hardwired zero, never busy
//  AW            5   register address width, clog2(NREG)
//  STALL_ON_WAW  1   1: stall an issue whose destination is already busy; 0: check RAW only
// PORTS
//  clk           in   1   clock, rising edge
//  rst           in   1   reset, asynchronous, active high
//  is_valid      in   1   ID holds an instruction requesting issue
//  is_useA       in   1   instruction reads addrA
//  is_addrA      in   AW  A source register
//  is_useB       in   1   instruction reads addrB
//  is_addrB      in   AW  B source register
//  is_we         in   1   instruction writes a register
//  is_addrW      in   AW  destination register
//  is_stall      out  1   hazard; issue not accepted this cycle (combinational)
//  wb_we         in   1   write landing at register-file W port this cycle
//  wb_addrW      in   AW  register being written
//  kill_we       in   1   squash a pending write (instruction flushed after issue)
//  kill_addrW    in   AW  register whose pending write is cancelled
//  busy_vec      out  NREG registered pending bits; bit 0 always 0
//  busy_cnt      out  AW+1 number of set busy bits, 0..31 (registered)
//  sb_idle       out  1   busy_cnt==0
//  sb_err        out  1   sticky protocol-error flag
// BEHAVIOUR
//  - Reset: busy_vec=0, busy_cnt=0, sb_idle=1, sb_err=0. Reset mid-operation drops all pending state immediately.
//  - Hazard checks: hzA = is_useA & addrA!=0 & busy[addrA]; hzB likewise.
//    hzW = STALL_ON_WAW & is_we & addrW!=0 & busy[addrW].
//  - is_stall = is_valid & (hzA|hzB|hzW).
//  - is_stall reads registered busy_vec only; a wb to the same register in the same cycle does not unstall (no bypass).
//    Minimum RAW stall is therefore 1 cycle after the wb cycle.
//  - Accept = is_valid & !is_stall. On accept with is_we & addrW!=0: busy[addrW] <= 1 at the next edge.
//  - Clear: wb_we & wb_addrW!=0 clears busy[wb_addrW]; kill_we & kill_addrW!=0 clears busy[kill_addrW]. Both take effect at the next edge.
//  - Writes to register 0 (issue, wb, kill) are ignored entirely and never flag an error.
//  - Simultaneous events, same register:
//    - set+clear: clear applies first, then set, so the bit ends at 1. Reachable only when STALL_ON_WAW=0.
//    - wb and kill on the same register: bit cleared, sb_err <= 1.
//  - wb or kill to a non-busy register (nonzero address): sb_err <= 1; busy_vec unchanged for that entry.
//  - busy_cnt is updated in the same edge as busy_vec:
//    - next = cur + set - clears, width AW+1.
//    - Never wraps: it cannot exceed 31 because entry 0 is never set.
//  - sb_err clears only on rst.
//  - Latency: set/clear is visible on busy_vec and is_stall exactly 1 cycle after the triggering edge.
// STRUCTURE
//  - Shared package: NREG, AW, REG_ZERO=0.
//  - One sub-module, popcount_ones(NREG), for busy_cnt.
//    Either recompute busy_cnt from next busy_vec or keep an incremental counter; the two must agree.
//  - Per-entry next-state logic lives in a generate loop; entry 0 is a constant 0.
// TESTING
//  1. Reset asserted mid-run with busy_vec=0x0000_00F0 -> busy_vec=0, busy_cnt=0, sb_idle=1, sb_err=0 with no clk edge.
//  2. Issue we to $8; next cycle issue useA $8 -> is_stall=1.
//     wb $8 in cycle N -> stall still 1 in N, 0 in N+1.
//  3. Issue we $0 and then useA $0 -> never stall; busy_vec stays 0; no sb_err.
//  4. STALL_ON_WAW=1: $5 busy, issue we $5 -> stall. STALL_ON_WAW=0: wb $5 plus issue we $5 in the same cycle -> busy[5]=1, busy_cnt unchanged.
//  5. Set $3,$4,$31 -> busy_cnt=3. kill $4 and wb $3 in the same cycle -> busy_cnt=1, busy_vec=0x8000_0000.
//  6. wb $9 while $9 not busy -> sb_err=1 and it stays 1. wb and kill on busy $7 in the same cycle -> busy[7]=0, sb_err=1.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard.
//   NREG     : number of architectural registers (entry 0 is the hardwired zero)
//   AW       : register address width
//   REG_ZERO : index of the hardwired-zero register; writes to it are ignored
//   entry_ev_t : the per-entry events seen in one cycle (set / wb clear / kill clear)
package reg_scoreboard_pkg;

  localparam int NREG     = 32;
  localparam int AW       = 5;
  localparam int REG_ZERO = 0;

  typedef struct packed {
    logic set;   // accepted issue targets this entry
    logic wb;    // write-back lands on this entry
    logic kill;  // flushed instruction cancels this entry
  } entry_ev_t;

endpackage

// File: rtl/reg_scoreboard_popcount.sv
// popcount_ones: combinational count of set bits in a vector.
//   vec : input vector, N bits
//   cnt : number of ones in vec, CW bits (CW must hold N)
module popcount_ones #(
  parameter int N  = 32,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] cnt
);

  // NOTE: cnt is assigned before the loop so every path drives it; an
  // always_comb output left unassigned on some path would infer a latch.
  // NOTE: blocking '=' is correct here because the loop is a running sum
  // inside combinational logic; registers elsewhere use non-blocking '<='.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks registers with a write in flight so ID can stall on
// RAW (and optionally WAW) hazards while multi-cycle units write back out of
// order.
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   is_valid            : ID holds an instruction requesting issue
//   is_useA / is_addrA  : instruction reads source A
//   is_useB / is_addrB  : instruction reads source B
//   is_we / is_addrW    : instruction writes destination W
//   is_stall            : combinational hazard; the issue is not accepted
//   wb_we / wb_addrW    : write landing at the register-file W port
//   kill_we / kill_addrW: pending write cancelled by a flush
//   busy_vec            : registered pending bits, bit 0 always 0
//   busy_cnt            : registered count of pending bits
//   sb_idle             : nothing pending
//   sb_err              : sticky protocol error (clear of a non-pending entry,
//                         or wb and kill on the same entry in one cycle)
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG         = reg_scoreboard_pkg::NREG,
  parameter int AW           = reg_scoreboard_pkg::AW,
  parameter bit STALL_ON_WAW = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            is_valid,
  input  logic            is_useA,
  input  logic [AW-1:0]   is_addrA,
  input  logic            is_useB,
  input  logic [AW-1:0]   is_addrB,
  input  logic            is_we,
  input  logic [AW-1:0]   is_addrW,
  output logic            is_stall,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addrW,
  input  logic            kill_we,
  input  logic [AW-1:0]   kill_addrW,
  output logic [NREG-1:0] busy_vec,
  output logic [AW:0]     busy_cnt,
  output logic            sb_idle,
  output logic            sb_err
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] err_vec;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;
  logic            err_q;

  logic hz_a;
  logic hz_b;
  logic hz_w;
  logic accept;
  logic set_en;
  logic wb_en;
  logic kill_en;

  // Hazards look only at the registered busy bits: a write-back in this
  // cycle does not unstall its consumer until the following cycle.
  always_comb begin
    hz_a = is_useA && (is_addrA != AW'(REG_ZERO)) && busy_q[is_addrA];
    hz_b = is_useB && (is_addrB != AW'(REG_ZERO)) && busy_q[is_addrB];
    hz_w = STALL_ON_WAW && is_we && (is_addrW != AW'(REG_ZERO)) && busy_q[is_addrW];
  end

  assign is_stall = is_valid && (hz_a || hz_b || hz_w);
  assign accept   = is_valid && !is_stall;

  // Register 0 never becomes pending and its wb/kill are ignored, so every
  // event is qualified by a nonzero address here once.
  assign set_en  = accept && is_we && (is_addrW != AW'(REG_ZERO));
  assign wb_en   = wb_we && (wb_addrW != AW'(REG_ZERO));
  assign kill_en = kill_we && (kill_addrW != AW'(REG_ZERO));

  assign busy_d[0]  = 1'b0;
  assign err_vec[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_entry
    entry_ev_t ev;

    assign ev.set  = set_en && (is_addrW == AW'(i));
    assign ev.wb   = wb_en && (wb_addrW == AW'(i));
    assign ev.kill = kill_en && (kill_addrW == AW'(i));

    // Clear is applied before set, so a same-cycle clear and re-issue of the
    // same register leaves it pending (only possible without WAW stalls).
    assign busy_d[i] = ev.set || (busy_q[i] && !(ev.wb || ev.kill));

    // Protocol errors: double clear in one cycle, or clearing an entry that
    // has no write outstanding.
    assign err_vec[i] = (ev.wb && ev.kill) || ((ev.wb || ev.kill) && !busy_q[i]);
  end

  // Count is taken from the next-state vector so busy_cnt and busy_vec are
  // updated by the same edge and always agree.
  popcount_ones #(
    .N  (NREG),
    .CW (AW + 1)
  ) u_popcount (
    .vec (busy_d),
    .cnt (cnt_d)
  );

  // NOTE: the busy flags are reset, unlike a data RAM: a stale pending bit
  // after reset would stall ID forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      err_q  <= err_q || (|err_vec);
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;
  assign sb_idle  = (cnt_q == '0);
  assign sb_err   = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard. Two instances share all inputs: u_dut
// with WAW stalls enabled and u_dut0 with RAW-only checking. Stimulus drives
// one cycle at a time and queues the hand-computed outputs expected in that
// cycle; a monitor on the falling edge pops and compares them.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        is_valid;
  logic        is_useA;
  logic [4:0]  is_addrA;
  logic        is_useB;
  logic [4:0]  is_addrB;
  logic        is_we;
  logic [4:0]  is_addrW;
  logic        wb_we;
  logic [4:0]  wb_addrW;
  logic        kill_we;
  logic [4:0]  kill_addrW;

  logic        stall1;
  logic [31:0] vec1;
  logic [5:0]  cnt1;
  logic        idle1;
  logic        err1;

  logic        stall0;
  logic [31:0] vec0;
  logic [5:0]  cnt0;
  logic        idle0;
  logic        err0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    bit          sel;    // 0: WAW instance, 1: RAW-only instance
    logic        stall;
    logic [31:0] vec;
    logic [5:0]  cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  reg_scoreboard #(.NREG(32), .AW(5), .STALL_ON_WAW(1'b1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .is_valid   (is_valid),
    .is_useA    (is_useA),
    .is_addrA   (is_addrA),
    .is_useB    (is_useB),
    .is_addrB   (is_addrB),
    .is_we      (is_we),
    .is_addrW   (is_addrW),
    .is_stall   (stall1),
    .wb_we      (wb_we),
    .wb_addrW   (wb_addrW),
    .kill_we    (kill_we),
    .kill_addrW (kill_addrW),
    .busy_vec   (vec1),
    .busy_cnt   (cnt1),
    .sb_idle    (idle1),
    .sb_err     (err1)
  );

  reg_scoreboard #(.NREG(32), .AW(5), .STALL_ON_WAW(1'b0)) u_dut0 (
    .clk        (clk),
    .rst        (rst),
    .is_valid   (is_valid),
    .is_useA    (is_useA),
    .is_addrA   (is_addrA),
    .is_useB    (is_useB),
    .is_addrB   (is_addrB),
    .is_we      (is_we),
    .is_addrW   (is_addrW),
    .is_stall   (stall0),
    .wb_we      (wb_we),
    .wb_addrW   (wb_addrW),
    .kill_we    (kill_we),
    .kill_addrW (kill_addrW),
    .busy_vec   (vec0),
    .busy_cnt   (cnt0),
    .sb_idle    (idle0),
    .sb_err     (err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
    end
  endtask

  // Monitor: compares every queued expectation against the live outputs.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (!e.sel) begin
        check({e.name, "/stall"}, 32'(stall1), 32'(e.stall));
        check({e.name, "/busy_vec"}, vec1, e.vec);
        check({e.name, "/busy_cnt"}, 32'(cnt1), 32'(e.cnt));
        check({e.name, "/sb_idle"}, 32'(idle1), 32'(e.cnt == 6'd0));
        check({e.name, "/sb_err"}, 32'(err1), 32'(e.err));
      end else begin
        check({e.name, "/stall"}, 32'(stall0), 32'(e.stall));
        check({e.name, "/busy_vec"}, vec0, e.vec);
        check({e.name, "/busy_cnt"}, 32'(cnt0), 32'(e.cnt));
        check({e.name, "/sb_idle"}, 32'(idle0), 32'(e.cnt == 6'd0));
        check({e.name, "/sb_err"}, 32'(err0), 32'(e.err));
      end
    end
  end

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    is_valid   = 1'b0;
    is_useA    = 1'b0;
    is_addrA   = '0;
    is_useB    = 1'b0;
    is_addrB   = '0;
    is_we      = 1'b0;
    is_addrW   = '0;
    wb_we      = 1'b0;
    wb_addrW   = '0;
    kill_we    = 1'b0;
    kill_addrW = '0;
  endtask

  task automatic issue(input logic v, input logic ua, input logic [4:0] a,
                       input logic ub, input logic [4:0] b,
                       input logic we, input logic [4:0] w);
    is_valid = v;
    is_useA  = ua;
    is_addrA = a;
    is_useB  = ub;
    is_addrB = b;
    is_we    = we;
    is_addrW = w;
  endtask

  task automatic wb(input logic [4:0] a);
    wb_we    = 1'b1;
    wb_addrW = a;
  endtask

  task automatic kill(input logic [4:0] a);
    kill_we    = 1'b1;
    kill_addrW = a;
  endtask

  task automatic expect_out(input string nm, input bit sel, input logic st,
                            input logic [31:0] v, input logic [5:0] c, input logic e);
    exp_t x;
    x.name  = nm;
    x.sel   = sel;
    x.stall = st;
    x.vec   = v;
    x.cnt   = c;
    x.err   = e;
    exp_q.push_back(x);
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    expect_out("rst_init", 0, 0, 32'h0, 6'd0, 0);
    expect_out("rst_init_raw", 1, 0, 32'h0, 6'd0, 0);
    cyc(); rst = 1'b0;
    expect_out("post_rst", 0, 0, 32'h0, 6'd0, 0);

    // RAW stall on $8, released one cycle after the write-back cycle
    cyc(); issue(1, 0, 0, 0, 0, 1, 8);
    expect_out("raw_set8", 0, 0, 32'h0, 6'd0, 0);
    cyc(); issue(0, 1, 8, 0, 0, 0, 0);
    expect_out("raw_novalid", 0, 0, 32'h100, 6'd1, 0);
    cyc(); issue(1, 1, 8, 0, 0, 0, 0);
    expect_out("raw_stall", 0, 1, 32'h100, 6'd1, 0);
    cyc(); issue(1, 1, 8, 0, 0, 0, 0); wb(8);
    expect_out("raw_wb_cycle", 0, 1, 32'h100, 6'd1, 0);
    cyc(); issue(1, 1, 8, 0, 0, 0, 0);
    expect_out("raw_after_wb", 0, 0, 32'h0, 6'd0, 0);

    // Register 0 is never busy and its wb/kill never flag errors
    cyc(); issue(1, 0, 0, 0, 0, 1, 0);
    expect_out("zero_we", 0, 0, 32'h0, 6'd0, 0);
    cyc(); issue(1, 1, 0, 0, 0, 1, 0);
    expect_out("zero_use", 0, 0, 32'h0, 6'd0, 0);
    cyc(); issue(1, 0, 0, 1, 0, 0, 0); wb(0); kill(0);
    expect_out("zero_wbkill", 0, 0, 32'h0, 6'd0, 0);
    cyc();
    expect_out("zero_quiet", 0, 0, 32'h0, 6'd0, 0);

    // WAW stall with STALL_ON_WAW=1, set+clear ordering with STALL_ON_WAW=0
    cyc(); issue(1, 0, 0, 0, 0, 1, 5);
    expect_out("waw_set5", 0, 0, 32'h0, 6'd0, 0);
    cyc(); issue(1, 0, 0, 0, 0, 1, 5);
    expect_out("waw_stall", 0, 1, 32'h20, 6'd1, 0);
    cyc(); issue(1, 0, 0, 1, 5, 1, 6);
    expect_out("raw_b_stall", 0, 1, 32'h20, 6'd1, 0);
    cyc();
    expect_out("stalled_no_set6", 0, 0, 32'h20, 6'd1, 0);
    cyc(); issue(1, 0, 0, 0, 0, 1, 5); wb(5);
    expect_out("setclr_raw_only", 1, 0, 32'h20, 6'd1, 0);
    expect_out("setclr_waw", 0, 1, 32'h20, 6'd1, 0);
    cyc();
    expect_out("setclr_raw_only_res", 1, 0, 32'h20, 6'd1, 0);
    expect_out("setclr_waw_res", 0, 0, 32'h0, 6'd0, 0);

    // Reset mid-run with $4..$7 pending
    cyc(); issue(1, 0, 0, 0, 0, 1, 4);
    expect_out("mid_s4", 0, 0, 32'h0, 6'd0, 0);
    cyc(); issue(1, 0, 0, 0, 0, 1, 5);
    expect_out("mid_s5", 0, 0, 32'h10, 6'd1, 0);
    cyc(); issue(1, 0, 0, 0, 0, 1, 6);
    expect_out("mid_s6", 0, 0, 32'h30, 6'd2, 0);
    cyc(); issue(1, 0, 0, 0, 0, 1, 7);
    expect_out("mid_s7", 0, 0, 32'h70, 6'd3, 0);
    cyc();
    expect_out("mid_full", 0, 0, 32'hF0, 6'd4, 0);
    cyc(); rst = 1'b1;
    expect_out("mid_rst", 0, 0, 32'h0, 6'd0, 0);
    expect_out("mid_rst_raw", 1, 0, 32'h0, 6'd0, 0);
    cyc(); rst = 1'b0;
    expect_out("mid_release", 0, 0, 32'h0, 6'd0, 0);

    // Count with $3,$4,$31; kill and wb in the same cycle
    cyc(); issue(1, 0, 0, 0, 0, 1, 3);
    expect_out("cnt_s3", 0, 0, 32'h0, 6'd0, 0);
    cyc(); issue(1, 0, 0, 0, 0, 1, 4);
    expect_out("cnt_s4", 0, 0, 32'h8, 6'd1, 0);
    cyc(); issue(1, 0, 0, 0, 0, 1, 31);
    expect_out("cnt_s31", 0, 0, 32'h18, 6'd2, 0);
    cyc();
    expect_out("cnt_three", 0, 0, 32'h8000_0018, 6'd3, 0);
    cyc(); kill(4); wb(3);
    expect_out("cnt_clr_cycle", 0, 0, 32'h8000_0018, 6'd3, 0);
    cyc();
    expect_out("cnt_one", 0, 0, 32'h8000_0000, 6'd1, 0);

    // wb and kill on busy $7 in the same cycle
    cyc(); issue(1, 0, 0, 0, 0, 1, 7);
    expect_out("dbl_s7", 0, 0, 32'h8000_0000, 6'd1, 0);
    cyc();
    expect_out("dbl_busy", 0, 0, 32'h8000_0080, 6'd2, 0);
    cyc(); wb(7); kill(7);
    expect_out("dbl_cycle", 0, 0, 32'h8000_0080, 6'd2, 0);
    cyc(); issue(0, 1, 31, 0, 0, 0, 0);
    expect_out("dbl_result", 0, 0, 32'h8000_0000, 6'd1, 1);

    // wb to a non-busy register: sticky error
    cyc(); rst = 1'b1;
    expect_out("err_rst", 0, 0, 32'h0, 6'd0, 0);
    cyc(); rst = 1'b0; wb(9);
    expect_out("err_wb9", 0, 0, 32'h0, 6'd0, 0);
    cyc();
    expect_out("err_set", 0, 0, 32'h0, 6'd0, 1);
    cyc();
    expect_out("err_sticky", 0, 0, 32'h0, 6'd0, 1);
    cyc();
    expect_out("err_sticky2", 0, 0, 32'h0, 6'd0, 1);

    // Bounded wait for the monitor to drain the queue
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
